// File: rtl/ysyx_22050612_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_mem_arbiter_if
//
// Bundle of every handshake/bus signal around the memory arbiter:
//   ifu_*  : fetch requester (read-only), valid/ready request + rsp pulse
//   lsu_*  : load/store requester (read/write), valid/ready request + rsp pulse
//   mem_*  : the single shared memory port, valid/ready request and response
//
// Modports:
//   slave  : the arbiter's view (takes requests, drives memory side)
//   master : the environment's view (requesters + memory model)
// ---------------------------------------------------------------------------
interface ysyx_22050612_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // fetch side
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_rsp_valid;
    logic [DATA_W-1:0]     ifu_rsp_data;

    // load/store side
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_rsp_valid;
    logic [DATA_W-1:0]     lsu_rsp_data;

    // memory side
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [DATA_W-1:0]     mem_rsp_data;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output mem_rsp_ready
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/ysyx_22050612_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_mem_arbiter
//
// Shares one memory port between instruction fetch (read-only) and the
// load/store path. One transaction in flight at a time:
//   IDLE : combinational grant, handshake latches the request fields
//   ADDR : mem_req_valid held with registered fields until mem_req_ready
//   WAIT : mem_rsp_ready high; response registered and pulsed to the owner
// Under contention the requester that was not granted last wins, so fetch
// and load/store alternate.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : ysyx_22050612_mem_arbiter_if.slave (ifu_*, lsu_*, mem_*)
//   busy       : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module ysyx_22050612_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_22050612_mem_arbiter_if.slave    bus,
    output logic                          busy
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;

    state_t            state, state_nxt;
    owner_t            owner, last_grant;
    req_t              req_q, req_sel;

    logic              gnt_ifu, gnt_lsu;
    logic              ifu_ready, lsu_ready, accept;
    logic              mem_req_valid, mem_rsp_ready, rsp_fire;

    logic              ifu_rsp_valid_q, lsu_rsp_valid_q;
    logic [DATA_W-1:0] ifu_rsp_data_q, lsu_rsp_data_q;

    // -----------------------------------------------------------------------
    // Grant: fetch wins when alone, or when both ask and load/store had the
    // previous grant. Load/store gets whatever fetch does not take.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_ifu = bus.ifu_req_valid &
                  (~bus.lsu_req_valid | (last_grant == OWN_LSU));
        gnt_lsu = bus.lsu_req_valid & ~gnt_ifu;
    end

    // Fetch requests are reads: force store fields to zero so the memory
    // never sees stale load/store data on a fetch.
    always_comb begin
        req_sel.addr  = bus.ifu_addr;
        req_sel.wen   = 1'b0;
        req_sel.wdata = '0;
        req_sel.wmask = '0;
        if (gnt_lsu) begin
            req_sel.addr  = bus.lsu_addr;
            req_sel.wen   = bus.lsu_wen;
            req_sel.wdata = bus.lsu_wdata;
            req_sel.wmask = bus.lsu_wmask;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        ifu_ready     = 1'b0;
        lsu_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        unique case (state)
            IDLE: begin
                ifu_ready = gnt_ifu;
                lsu_ready = gnt_lsu;
                if (gnt_ifu | gnt_lsu) state_nxt = ADDR;
            end
            ADDR: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                mem_rsp_ready = 1'b1;
                if (bus.mem_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = ifu_ready | lsu_ready;
    // mem_rsp_valid only counts while mem_rsp_ready is high, so a late
    // response after reset or an early one during ADDR is dropped.
    assign rsp_fire = mem_rsp_ready & bus.mem_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;   // first conflict after reset goes to fetch
            req_q      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q      <= req_sel;
                owner      <= gnt_lsu ? OWN_LSU : OWN_IFU;
                last_grant <= gnt_lsu ? OWN_LSU : OWN_IFU;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response return: one-cycle pulse to the owner only; data registers
    // hold until the next response for the same requester.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= '0;
            lsu_rsp_data_q  <= '0;
        end else begin
            ifu_rsp_valid_q <= rsp_fire & (owner == OWN_IFU);
            lsu_rsp_valid_q <= rsp_fire & (owner == OWN_LSU);
            if (rsp_fire && owner == OWN_IFU) ifu_rsp_data_q <= bus.mem_rsp_data;
            if (rsp_fire && owner == OWN_LSU) lsu_rsp_data_q <= bus.mem_rsp_data;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.ifu_req_ready = ifu_ready;
    assign bus.lsu_req_ready = lsu_ready;
    assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
    assign bus.ifu_rsp_data  = ifu_rsp_data_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.lsu_rsp_data  = lsu_rsp_data_q;

    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_addr      = req_q.addr;
    assign bus.mem_wen       = req_q.wen;
    assign bus.mem_wdata     = req_q.wdata;
    assign bus.mem_wmask     = req_q.wmask;
    assign bus.mem_rsp_ready = mem_rsp_ready;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_22050612_mem_arbiter: reset checks, a vector table of
// grant/transfer cases, hand-written multi-cycle sequences and a randomized
// run against a transaction-level model (last-grant bit + expected data).
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ysyx_22050612_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int checks = 0;
    int errors = 0;

    // reference model state: 1 = fetch, 2 = load/store
    int          last_g;
    logic [63:0] exp_ifu_d, exp_lsu_d;
    bit          lsu_d_known;

    typedef struct {
        bit          iv, lv, lw;
        logic [63:0] ia, la, wd;
        logic [7:0]  wm;
        logic [63:0] rd;
        int          g;      // expected winner: 0 none, 1 fetch, 2 load/store
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(bit iv, bit lv, bit lw, logic [63:0] ia,
                                logic [63:0] la, logic [63:0] wd,
                                logic [7:0] wm, logic [63:0] rd, int g);
        vec_t v;
        v.iv = iv; v.lv = lv; v.lw = lw; v.ia = ia; v.la = la;
        v.wd = wd; v.wm = wm; v.rd = rd; v.g = g;
        return v;
    endfunction

    function automatic int predict(bit iv, bit lv);
        if (iv && lv) return (last_g == 2) ? 1 : 2;
        if (iv) return 1;
        if (lv) return 2;
        return 0;
    endfunction

    function automatic logic [63:0] junk();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    endtask

    task automatic model_reset();
        last_g = 2; exp_ifu_d = '0; exp_lsu_d = '0; lsu_d_known = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, "ifu_req_ready", bus.ifu_req_ready, 0);
        chk(tag, "lsu_req_ready", bus.lsu_req_ready, 0);
        chk(tag, "ifu_rsp_valid", bus.ifu_rsp_valid, 0);
        chk(tag, "ifu_rsp_data",  bus.ifu_rsp_data, 0);
        chk(tag, "lsu_rsp_valid", bus.lsu_rsp_valid, 0);
        chk(tag, "lsu_rsp_data",  bus.lsu_rsp_data, 0);
        chk(tag, "mem_req_valid", bus.mem_req_valid, 0);
        chk(tag, "mem_addr",      bus.mem_addr, 0);
        chk(tag, "mem_wen",       bus.mem_wen, 0);
        chk(tag, "mem_wdata",     bus.mem_wdata, 0);
        chk(tag, "mem_wmask",     bus.mem_wmask, 0);
        chk(tag, "mem_rsp_ready", bus.mem_rsp_ready, 0);
        chk(tag, "busy",          busy, 0);
    endtask

    task automatic chk_data(input string tag);
        chk(tag, "ifu_rsp_data", bus.ifu_rsp_data, exp_ifu_d);
        if (lsu_d_known) chk(tag, "lsu_rsp_data", bus.lsu_rsp_data, exp_lsu_d);
    endtask

    // One complete transaction starting in IDLE. The loser of a conflict
    // keeps its valid up until the response cycle to prove it is not
    // granted outside IDLE.
    task automatic run_txn(input string tag, input bit iv, input bit lv,
                           input bit lw, input logic [63:0] ia,
                           input logic [63:0] la, input logic [63:0] wd,
                           input logic [7:0] wm, input logic [63:0] rd,
                           input int req_wait, input int rsp_wait,
                           input bit spurious, input int exp_g);
        logic [63:0] e_addr, e_wdata;
        logic        e_wen;
        logic [7:0]  e_wmask;
        bus.ifu_req_valid = iv; bus.ifu_addr = ia;
        bus.lsu_req_valid = lv; bus.lsu_addr = la; bus.lsu_wen = lw;
        bus.lsu_wdata = wd; bus.lsu_wmask = wm;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk(tag, "ifu_req_ready", bus.ifu_req_ready, (exp_g == 1));
        chk(tag, "lsu_req_ready", bus.lsu_req_ready, (exp_g == 2));
        chk(tag, "busy_idle", busy, 0);
        if (exp_g == 0) begin
            tick();
            chk(tag, "busy_no_req", busy, 0);
            bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
            return;
        end
        if (exp_g == 1) begin
            e_addr = ia; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
        end else begin
            e_addr = la; e_wen = lw; e_wdata = wd; e_wmask = wm;
        end
        last_g = exp_g;
        tick();
        if (exp_g == 1) bus.ifu_req_valid = 1'b0;
        else            bus.lsu_req_valid = 1'b0;
        // ADDR: request held stable until mem_req_ready
        for (int w = 0; w <= req_wait; w++) begin
            bus.mem_req_ready = (w == req_wait);
            bus.mem_rsp_valid = spurious;
            bus.mem_rsp_data  = junk();
            @(negedge clk);
            chk(tag, "mem_req_valid", bus.mem_req_valid, 1);
            chk(tag, "mem_addr",      bus.mem_addr, e_addr);
            chk(tag, "mem_wen",       bus.mem_wen, e_wen);
            chk(tag, "mem_wdata",     bus.mem_wdata, e_wdata);
            chk(tag, "mem_wmask",     bus.mem_wmask, e_wmask);
            chk(tag, "mem_rsp_ready_addr", bus.mem_rsp_ready, 0);
            chk(tag, "busy_addr",     busy, 1);
            chk(tag, "ready_addr",    {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            chk(tag, "rsp_valid_addr", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
            tick();
        end
        // WAIT: response accepted on its first valid cycle
        for (int w = 0; w <= rsp_wait; w++) begin
            bus.mem_req_ready = 1'($urandom_range(0, 1));
            bus.mem_rsp_valid = (w == rsp_wait);
            bus.mem_rsp_data  = (w == rsp_wait) ? rd : junk();
            @(negedge clk);
            chk(tag, "mem_rsp_ready_wait", bus.mem_rsp_ready, 1);
            chk(tag, "mem_req_valid_wait", bus.mem_req_valid, 0);
            chk(tag, "busy_wait",  busy, 1);
            chk(tag, "ready_wait", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            chk(tag, "rsp_valid_wait", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
            tick();
        end
        bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_data = junk();
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        if (exp_g == 1) exp_ifu_d = rd;
        else if (!lw) begin exp_lsu_d = rd; lsu_d_known = 1'b1; end
        else lsu_d_known = 1'b0;
        @(negedge clk);
        chk(tag, "ifu_rsp_valid", bus.ifu_rsp_valid, (exp_g == 1));
        chk(tag, "lsu_rsp_valid", bus.lsu_rsp_valid, (exp_g == 2));
        chk(tag, "busy_rsp", busy, 0);
        chk_data(tag);
        tick();
        @(negedge clk);
        chk(tag, "rsp_pulse_end", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
        chk_data({tag, "_hold"});
        tick();
    endtask

    initial begin
        int iv, lv, r;
        logic [63:0] d1, d2;

        // ---------------- reset values ----------------
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        tick();

        // ---------------- reset mid-WAIT ----------------
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 64'h8000_3000; bus.lsu_wen = 1'b0;
        tick();
        bus.lsu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_wait", "busy", busy, 1);
        chk("rst_wait", "mem_rsp_ready", bus.mem_rsp_ready, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_all_zero("rst_release");
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        chk("late_rsp", "mem_rsp_ready", bus.mem_rsp_ready, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_rsp", "rsp_valid", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
        chk("late_rsp", "ifu_rsp_data", bus.ifu_rsp_data, 0);
        chk("late_rsp", "lsu_rsp_data", bus.lsu_rsp_data, 0);
        chk("late_rsp", "busy", busy, 0);
        tick();

        // ---------------- vector table ----------------
        tbl[0]  = mk(1, 1, 0, 64'h8000_0100, 64'h8000_2000, 64'h0, 8'h00, 64'hAAAA_0000_0000_0001, 1);
        tbl[1]  = mk(1, 1, 0, 64'h8000_0104, 64'h8000_2008, 64'h0, 8'hFF, 64'hBBBB_0000_0000_0002, 2);
        tbl[2]  = mk(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 64'h0000_0000_0010_0073, 1);
        tbl[3]  = mk(0, 1, 1, 64'h0, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 2);
        tbl[4]  = mk(1, 1, 1, 64'h8000_0108, 64'h8000_1008, 64'hCAFE, 8'hF0, 64'hCCCC_0000_0000_0003, 1);
        tbl[5]  = mk(0, 0, 0, 64'h8000_010C, 64'h8000_100C, 64'h0, 8'h00, 64'h0, 0);
        tbl[6]  = mk(0, 1, 0, 64'h0, 64'h8000_2010, 64'h5555, 8'h00, 64'hDDDD_0000_0000_0004, 2);
        tbl[7]  = mk(1, 1, 1, 64'h8000_0200, 64'h8000_4000, 64'h1, 8'h01, 64'h1111, 1);
        tbl[8]  = mk(1, 1, 1, 64'h8000_0200, 64'h8000_4000, 64'h1, 8'h01, 64'h2222, 2);
        tbl[9]  = mk(1, 1, 0, 64'h8000_0204, 64'h8000_4008, 64'h2, 8'h03, 64'h3333, 1);
        tbl[10] = mk(1, 1, 0, 64'h8000_0204, 64'h8000_4008, 64'h2, 8'h03, 64'h4444, 2);
        for (int i = 0; i < 11; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].iv, tbl[i].lv, tbl[i].lw,
                    tbl[i].ia, tbl[i].la, tbl[i].wd, tbl[i].wm, tbl[i].rd,
                    0, 0, 1'b0, tbl[i].g);

        // ---------------- back-pressure ----------------
        run_txn("bp", 1, 0, 0, 64'h8000_0500, 64'h0, 64'h0, 8'h0,
                64'h0123_4567_89AB_CDEF, 5, 3, 1'b1, predict(1, 0));

        // ---------------- back-to-back ----------------
        d1 = 64'hFEED_0000_0000_0001;
        d2 = 64'hFEED_0000_0000_0002;
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 64'h8000_6000; bus.lsu_wen = 1'b0;
        @(negedge clk);
        chk("b2b", "lsu_req_ready_c0", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = d1;
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 64'h8000_0600;
        @(negedge clk);
        chk("b2b", "ifu_req_ready_c2", bus.ifu_req_ready, 0);
        tick();
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = junk();
        @(negedge clk);
        chk("b2b", "lsu_rsp_valid_c3", bus.lsu_rsp_valid, 1);
        chk("b2b", "lsu_rsp_data_c3", bus.lsu_rsp_data, d1);
        chk("b2b", "ifu_req_ready_c3", bus.ifu_req_ready, 1);
        chk("b2b", "ifu_rsp_valid_c3", bus.ifu_rsp_valid, 0);
        tick();
        bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("b2b", "lsu_rsp_valid_c4", bus.lsu_rsp_valid, 0);
        chk("b2b", "mem_addr_c4", bus.mem_addr, 64'h8000_0600);
        chk("b2b", "mem_wen_c4", bus.mem_wen, 0);
        tick();
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = d2;
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("b2b", "ifu_rsp_valid_c6", bus.ifu_rsp_valid, 1);
        chk("b2b", "ifu_rsp_data_c6", bus.ifu_rsp_data, d2);
        chk("b2b", "lsu_rsp_valid_c6", bus.lsu_rsp_valid, 0);
        tick();
        last_g = 1; exp_lsu_d = d1; lsu_d_known = 1'b1; exp_ifu_d = d2;

        // ---------------- randomized vs model ----------------
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 3));
            iv = r & 1;
            lv = (r >> 1) & 1;
            run_txn($sformatf("rnd%0d", n), iv[0], lv[0], 1'($urandom_range(0, 1)),
                    junk(), junk(), junk(), 8'($urandom), junk(),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), predict(iv[0], lv[0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
